// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: latches ecall / timer interrupt / mret at commit, flushes,
// waits for the pipeline to drain, pulses the CSR writes once, then holds a redirect to IFU.
module trap_ctrl #(
   parameter int XLEN         = 64,
   parameter int MCAUSE_ECALL = 11,
   parameter int MCAUSE_MTI   = 7
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_commit_valid,
   input  logic [XLEN-1:0] i_commit_pc,
   input  logic [XLEN-1:0] i_commit_next_pc,
   input  logic            i_ecall,
   input  logic            i_mret,
   input  logic            i_pipe_empty,
   input  logic [XLEN-1:0] i_mtvec,
   input  logic [XLEN-1:0] i_mepc,
   input  logic [XLEN-1:0] i_mstatus,
   input  logic [XLEN-1:0] i_mie,
   input  logic [XLEN-1:0] i_mip,
   input  logic            i_redirect_ready,
   output logic            o_flush,
   output logic            o_stall_commit,
   output logic            o_mepc_wen,
   output logic [XLEN-1:0] o_mepc_wdata,
   output logic            o_mcause_wen,
   output logic [XLEN-1:0] o_mcause_wdata,
   output logic            o_mstatus_wen,
   output logic [XLEN-1:0] o_mstatus_wdata,
   output logic            o_redirect_valid,
   output logic [XLEN-1:0] o_redirect_pc,
   output logic [31:0]     o_trap_cnt,
   output logic [1:0]      o_dbg_state
);

   // Handshake: o_redirect_valid stays high with o_redirect_pc held until a cycle in which
   // i_redirect_ready is also high; that cycle completes the transfer and returns to IDLE.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_WRITE = 2'd2,
      S_REDIR = 2'd3
   } state_t;

   state_t          state;
   logic            kind_ret;
   logic [XLEN-1:0] epc;
   logic [XLEN-1:0] cause;

   logic            int_pend;
   logic            event_hit;
   logic            in_write;
   logic            in_redir;
   logic [XLEN-1:0] vec_base;
   logic [XLEN-1:0] trap_target;
   logic [XLEN-1:0] mstatus_trap;
   logic [XLEN-1:0] mstatus_ret;

   assign int_pend  = i_mstatus[3] & i_mie[7] & i_mip[7];
   assign event_hit = (state == S_IDLE) & i_commit_valid & (i_ecall | i_mret | int_pend);
   assign in_write  = (state == S_WRITE);
   assign in_redir  = (state == S_REDIR);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= S_IDLE;
         kind_ret   <= 1'b0;
         epc        <= '0;
         cause      <= '0;
         o_trap_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_commit_valid) begin
                  if (i_ecall) begin
                     kind_ret <= 1'b0;
                     epc      <= i_commit_pc;
                     cause    <= XLEN'(MCAUSE_ECALL);
                     state    <= S_DRAIN;
                  end else if (i_mret) begin
                     kind_ret <= 1'b1;
                     state    <= S_DRAIN;
                  end else if (int_pend) begin
                     // Interrupt is taken after the committing instruction, so resume at its successor.
                     kind_ret <= 1'b0;
                     epc      <= i_commit_next_pc;
                     cause    <= {1'b1, (XLEN-1)'(MCAUSE_MTI)};
                     state    <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (i_pipe_empty) begin
                  state <= S_WRITE;
                  if (!kind_ret) o_trap_cnt <= o_trap_cnt + 32'd1;
               end
            end
            S_WRITE: state <= S_REDIR;
            S_REDIR: begin
               if (i_redirect_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      mstatus_trap         = i_mstatus;
      mstatus_trap[7]      = i_mstatus[3];
      mstatus_trap[3]      = 1'b0;
      mstatus_trap[12:11]  = 2'b11;
      mstatus_ret          = i_mstatus;
      mstatus_ret[3]       = i_mstatus[7];
      mstatus_ret[7]       = 1'b1;
      mstatus_ret[12:11]   = 2'b11;
   end

   // Vectored mode only offsets interrupts; synchronous exceptions always land on the base.
   assign vec_base    = {i_mtvec[XLEN-1:2], 2'b00};
   assign trap_target = ((i_mtvec[1:0] == 2'b01) && cause[XLEN-1])
                        ? vec_base + XLEN'(4 * MCAUSE_MTI) : vec_base;

   assign o_flush          = i_rst_n & event_hit;
   assign o_stall_commit   = (state != S_IDLE);
   assign o_mepc_wen       = in_write & ~kind_ret;
   assign o_mepc_wdata     = o_mepc_wen ? epc : '0;
   assign o_mcause_wen     = in_write & ~kind_ret;
   assign o_mcause_wdata   = o_mcause_wen ? cause : '0;
   assign o_mstatus_wen    = in_write;
   assign o_mstatus_wdata  = !in_write ? '0 : (kind_ret ? mstatus_ret : mstatus_trap);
   assign o_redirect_valid = in_redir;
   assign o_redirect_pc    = !in_redir ? '0 : (kind_ret ? i_mepc : trap_target);
   assign o_dbg_state      = state;

   logic unused_csr_bits;
   assign unused_csr_bits = ^{i_mie[XLEN-1:8], i_mie[6:0], i_mip[XLEN-1:8], i_mip[6:0]};

endmodule
